// File: rtl/bf_pass_scheduler.sv
// Bellman-Ford pass scheduler.
// Writes the initial distance array, then streams edge indices to the relax
// datapath pass by pass. Stops early on a pass with no updates, or after the
// V-th (detection) pass, which reports a negative cycle if it still updates.
module bf_pass_scheduler #(
   parameter int                ADDR_W  = 13,
   parameter int                DIST_W  = 16,
   parameter logic [DIST_W-1:0] INF     = {DIST_W{1'b1}},
   parameter int                MAX_OUT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_nodes,
   input  logic [ADDR_W-1:0] num_edges,
   input  logic [ADDR_W-1:0] src_node,
   output logic [ADDR_W-1:0] OMWAR,
   output logic [DIST_W-1:0] OMWDR,
   output logic              OMWE,
   output logic              edge_valid,
   output logic [ADDR_W-1:0] edge_addr,
   input  logic              edge_ready,
   input  logic              resp_valid,
   input  logic              resp_updated,
   output logic [ADDR_W-1:0] pass_count,
   output logic              busy,
   output logic              Finish,
   output logic              NegCycle
);

   localparam int OUT_W = $clog2(MAX_OUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_RELAX, S_DRAIN, S_EVAL, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  v_q, v_d;
   logic [ADDR_W-1:0]  e_q, e_d;
   logic [ADDR_W-1:0]  src_q, src_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;   // init write address
   logic [ADDR_W-1:0]  idx_q, idx_d;     // next edge index to issue
   logic [ADDR_W-1:0]  pass_q, pass_d;
   logic [OUT_W-1:0]   out_q, out_d;     // edges in flight in the datapath
   logic               pass_upd_q, pass_upd_d;
   logic               neg_q, neg_d;

   logic               accept;
   logic               resp_ok;

   // A handshake moves one edge into the datapath; responses with nothing
   // outstanding are stale (e.g. from before a reset) and are dropped.
   assign accept  = edge_valid & edge_ready;
   assign resp_ok = resp_valid & (out_q != '0);

   // State and working registers, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         v_q        <= '0;
         e_q        <= '0;
         src_q      <= '0;
         addr_q     <= '0;
         idx_q      <= '0;
         pass_q     <= '0;
         out_q      <= '0;
         pass_upd_q <= 1'b0;
         neg_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         v_q        <= v_d;
         e_q        <= e_d;
         src_q      <= src_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         pass_q     <= pass_d;
         out_q      <= out_d;
         pass_upd_q <= pass_upd_d;
         neg_q      <= neg_d;
      end
   end

   // Next-state logic of the pass sequencer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = (num_nodes == '0) ? S_DONE : S_INIT;
         end
         S_INIT: begin
            if (addr_q == v_q - ADDR_W'(1)) state_d = S_RELAX;
         end
         S_RELAX: begin
            if (idx_q >= e_q) state_d = S_DRAIN;
            else if (accept && (idx_q == e_q - ADDR_W'(1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_q == '0) state_d = S_EVAL;
         end
         S_EVAL: begin
            // The V-th pass is the detection pass: no further passes after it.
            if (!pass_upd_q || (pass_q == v_q)) state_d = S_DONE;
            else                                state_d = S_RELAX;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counters, latched configuration and pass bookkeeping.
   always_comb begin
      v_d        = v_q;
      e_d        = e_q;
      src_d      = src_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      pass_upd_d = pass_upd_q;
      neg_d      = neg_q;

      unique case ({accept, resp_ok})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase

      if (resp_ok && resp_updated) pass_upd_d = 1'b1;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               v_d        = num_nodes;
               e_d        = num_edges;
               src_d      = src_node;
               addr_d     = '0;
               idx_d      = '0;
               pass_d     = '0;
               pass_upd_d = 1'b0;
               neg_d      = 1'b0;
            end
         end
         S_INIT: begin
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == v_q - ADDR_W'(1)) begin
               pass_d     = ADDR_W'(1);
               pass_upd_d = 1'b0;
               idx_d      = '0;
            end
         end
         S_RELAX: begin
            if (accept) idx_d = idx_q + ADDR_W'(1);
         end
         S_EVAL: begin
            if (pass_upd_q && (pass_q != v_q)) begin
               pass_d     = pass_q + ADDR_W'(1);
               pass_upd_d = 1'b0;
               idx_d      = '0;
            end else begin
               neg_d = pass_upd_q;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state; memory and edge ports are quiet outside
   // their own phases.
   always_comb begin
      OMWE       = (state_q == S_INIT);
      OMWAR      = (state_q == S_INIT) ? addr_q : '0;
      OMWDR      = '0;
      if (state_q == S_INIT) OMWDR = (addr_q == src_q) ? '0 : INF;
      edge_valid = (state_q == S_RELAX) && (idx_q < e_q) &&
                   (out_q < OUT_W'(MAX_OUT));
      edge_addr  = (state_q == S_RELAX) ? idx_q : '0;
      busy       = (state_q == S_INIT) || (state_q == S_RELAX) ||
                   (state_q == S_DRAIN) || (state_q == S_EVAL);
      Finish     = (state_q == S_DONE);
      NegCycle   = neg_q;
      pass_count = pass_q;
   end

endmodule
